// File: rtl/unpacker.sv
// unpacker: splits an LSB-first, contiguous stream of p-bit values carried in
// BIT_WIDTH-bit rows into one full-width value per output handshake.
// Values may straddle two rows; a 2*BIT_WIDTH window holds the pending bits.
// Optional macro UNPACKER_SIGN_EXT_EN: sign-extend o_out from bit p-1
// instead of zero-extending.
module unpacker #(
    parameter int BIT_WIDTH  = 16,
    parameter int PREC_BITS  = 5,
    parameter int COUNT_BITS = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [PREC_BITS-1:0]  i_prec,
    input  logic [COUNT_BITS-1:0] i_count,
    input  logic [BIT_WIDTH-1:0]  i_row,
    input  logic                  i_row_valid,
    output logic                  o_row_ready,
    output logic [BIT_WIDTH-1:0]  o_out,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int WIN_W  = 2 * BIT_WIDTH;
    localparam int FILL_W = $clog2(WIN_W) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                  state;
    state_t                  state_nx;
    logic [WIN_W-1:0]        window;
    logic [FILL_W-1:0]       fill;
    logic [COUNT_BITS-1:0]   count;
    logic [PREC_BITS-1:0]    prec;
    logic [PREC_BITS-1:0]    prec_lat;
    logic [FILL_W-1:0]       prec_f;
    logic                    row_xfer;
    logic                    val_xfer;
    logic [BIT_WIDTH-1:0]    low_bits;
    logic [BIT_WIDTH-1:0]    val_mask;
    logic [BIT_WIDTH-1:0]    val_ext;

    assign prec_f   = FILL_W'(prec);
    assign row_xfer = o_row_ready & i_row_valid;
    assign val_xfer = o_valid & i_ready;
    assign low_bits = window[BIT_WIDTH-1:0];

    // Clamp an out-of-range precision (0 or wider than a row) to a full row
    always_comb begin
        prec_lat = i_prec;
        if (i_prec == '0 || int'(i_prec) > BIT_WIDTH) begin
            prec_lat = PREC_BITS'(BIT_WIDTH);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and handshake/status outputs; row_ready and valid are
    // mutually exclusive because they split on fill < p
    always_comb begin
        state_nx    = state;
        o_row_ready = 1'b0;
        o_valid     = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_nx = (i_count == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                o_busy = 1'b1;
                if (fill < prec_f) begin
                    o_row_ready = 1'b1;
                end else begin
                    o_valid = 1'b1;
                    if (i_ready && count == COUNT_BITS'(1)) begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                o_busy   = 1'b1;
                o_done   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Window, fill level, remaining count and latched precision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window <= '0;
            fill   <= '0;
            count  <= '0;
            prec   <= PREC_BITS'(BIT_WIDTH);
        end else if (state == IDLE && i_start) begin
            window <= '0;
            fill   <= '0;
            count  <= i_count;
            prec   <= prec_lat;
        end else if (row_xfer) begin
            // fill < p <= BIT_WIDTH here, so the shifted row always fits
            window <= window | (WIN_W'(i_row) << fill);
            fill   <= fill + FILL_W'(BIT_WIDTH);
        end else if (val_xfer) begin
            window <= window >> prec;
            fill   <= fill - prec_f;
            count  <= count - COUNT_BITS'(1);
        end
    end

    // Select window[p-1:0] and extend it to a full-width value
    always_comb begin
        val_mask = '0;
        for (int unsigned i = 0; i < BIT_WIDTH; i++) begin
            if (i < 32'(prec)) begin
                val_mask[i] = 1'b1;
            end
        end
`ifdef UNPACKER_SIGN_EXT_EN
        val_ext = low_bits & val_mask;
        for (int unsigned i = 0; i < BIT_WIDTH; i++) begin
            if (i + 1 == 32'(prec) && low_bits[i]) begin
                val_ext = (low_bits & val_mask) | ~val_mask;
            end
        end
`else
        val_ext = low_bits & val_mask;
`endif
    end

    assign o_out = o_valid ? val_ext : '0;

endmodule

// File: tb/tb_unpacker.sv
// tb_unpacker: scoreboard bench for unpacker. Stimulus pushes expected
// values into exp_q; a negedge monitor pops and compares on each output
// handshake. A feeder process serves rows from row_q.
module tb_unpacker;

    localparam int BW = 16;
    localparam int PB = 5;
    localparam int CB = 16;

`ifdef UNPACKER_SIGN_EXT_EN
    localparam logic [BW-1:0] EXP_F  = 16'hFFFF;
    localparam logic [BW-1:0] EXP_FF = 16'hFFFF;
`else
    localparam logic [BW-1:0] EXP_F  = 16'h000F;
    localparam logic [BW-1:0] EXP_FF = 16'h00FF;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start;
    logic [PB-1:0] i_prec;
    logic [CB-1:0] i_count;
    logic [BW-1:0] i_row;
    logic          i_row_valid;
    logic          o_row_ready;
    logic [BW-1:0] o_out;
    logic          o_valid;
    logic          i_ready;
    logic          o_busy;
    logic          o_done;

    always #5 clk = ~clk;

    unpacker #(.BIT_WIDTH(BW), .PREC_BITS(PB), .COUNT_BITS(CB)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_prec(i_prec),
        .i_count(i_count), .i_row(i_row), .i_row_valid(i_row_valid),
        .o_row_ready(o_row_ready), .o_out(o_out), .o_valid(o_valid),
        .i_ready(i_ready), .o_busy(o_busy), .o_done(o_done)
    );

    int checks = 0;
    int errors = 0;
    int rows_taken = 0;
    int done_cnt = 0;
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] row_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Row source: presents row_q head, pops on handshake, checks 1-cycle latency
    initial begin
        i_row = '0;
        i_row_valid = 1'b0;
        forever begin
            logic take;
            @(negedge clk);
            take = rst_n && o_row_ready && i_row_valid;
            @(posedge clk);
            #1;
            if (take && row_q.size() > 0) begin
                void'(row_q.pop_front());
                rows_taken++;
                chk("row_to_valid_latency", {31'b0, o_valid}, 32'd1);
            end
            i_row_valid = (row_q.size() > 0);
            i_row = (row_q.size() > 0) ? row_q[0] : '0;
        end
    end

    // Monitor: scoreboard compare on output handshake, exclusivity, done count
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_done) done_cnt++;
            if (o_valid) chk("valid_rowready_excl", {31'b0, o_row_ready}, 32'd0);
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got 0x%0h expected no output", o_out);
                end else begin
                    chk("out_value", {16'b0, o_out}, {16'b0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic start(input int p, input int n);
        @(posedge clk);
        #1;
        i_start = 1'b1;
        i_prec  = PB'(p);
        i_count = CB'(n);
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (o_done) seen = 1'b1;
        end
        chk({name, "_done"}, {31'b0, seen}, 32'd1);
        @(negedge clk);
        chk({name, "_idle"}, {31'b0, o_busy}, 32'd0);
    endtask

    task automatic wait_valid(input string name);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (o_valid) seen = 1'b1;
        end
        chk({name, "_valid"}, {31'b0, seen}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int d0;
        i_start = 1'b0;
        i_prec  = '0;
        i_count = '0;
        i_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {12'b0, o_out, o_valid, o_row_ready, o_busy, o_done}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Full-width values, one per row
        row_q.push_back(16'h1234); row_q.push_back(16'hABCD); row_q.push_back(16'h0F0F);
        exp_q.push_back(16'h1234); exp_q.push_back(16'hABCD); exp_q.push_back(16'h0F0F);
        start(16, 3);
        wait_done("p16");
        chk("p16_rows_left", row_q.size(), 32'd0);
        chk("p16_exp_left", exp_q.size(), 32'd0);

        // 5-bit values 1..6 packed contiguously; value 4 straddles rows
        r0 = rows_taken;
        row_q.push_back(16'h0C41); row_q.push_back(16'h0C52); row_q.push_back(16'hFFFF);
        for (int v = 1; v <= 6; v++) exp_q.push_back(BW'(v));
        start(5, 6);
        wait_done("p5");
        chk("p5_rows_used", rows_taken - r0, 32'd2);
        chk("p5_rows_left", row_q.size(), 32'd1);
        chk("p5_exp_left", exp_q.size(), 32'd0);
        row_q.delete();

        // Precision 0 and >BIT_WIDTH both behave as full width
        row_q.push_back(16'hBEEF); exp_q.push_back(16'hBEEF);
        start(0, 1);
        wait_done("prec0");
        row_q.push_back(16'h8001); exp_q.push_back(16'h8001);
        start(20, 1);
        wait_done("prec20");
        chk("clamp_exp_left", exp_q.size(), 32'd0);

        // Backpressure: value held stable, no row requested, nothing lost
        i_ready = 1'b0;
        row_q.push_back(16'h000F); exp_q.push_back(EXP_F);
        start(4, 1);
        wait_valid("bp");
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_out", {16'b0, o_out}, {16'b0, EXP_F});
            chk("bp_hold_valid", {31'b0, o_valid}, 32'd1);
            chk("bp_no_rowready", {31'b0, o_row_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        i_ready = 1'b1;
        wait_done("bp");
        chk("bp_exp_left", exp_q.size(), 32'd0);

        // Zero count goes straight to DONE
        start(5, 0);
        @(negedge clk);
        chk("cnt0_done", {31'b0, o_done}, 32'd1);
        chk("cnt0_rowready", {31'b0, o_row_ready}, 32'd0);
        chk("cnt0_busy", {31'b0, o_busy}, 32'd1);
        @(negedge clk);
        chk("cnt0_after", {30'b0, o_done, o_busy}, 32'd0);

        // Asynchronous reset mid-transfer with o_valid high
        i_ready = 1'b0;
        row_q.push_back(16'h1234);
        start(8, 2);
        wait_valid("rst");
        d0 = done_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_outs", {12'b0, o_out, o_valid, o_row_ready, o_busy, o_done}, 32'd0);
        row_q.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        i_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_no_done", done_cnt, d0);
        row_q.push_back(16'h00FF); exp_q.push_back(EXP_FF);
        start(8, 1);
        wait_done("after_rst");
        chk("after_rst_exp_left", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
